alu_mem_datapath: RTL and testbench
===================================

ALU_MEM_DATAPATH -- requirements
Module: alu_mem_datapath

Interface
REQ-001 Parameter ADDR_W, default 6: data-memory word-address width; depth is 2^ADDR_W = 64 words of 32 bits.
REQ-002 The design SHALL use one clock and a synchronous, active-high reset.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 BusA  input  32  ALU operand A; for shifts, the value to be shifted.
REQ-006 BusB  input  32  ALU operand B; for shifts, bits [4:0] are the shift amount.
REQ-007 ALUOp  input  4  operation code; 4'b1111 means "decode Func".
REQ-008 Func  input  6  R-type function field.
REQ-009 MemRead  input  1  data-memory read enable.
REQ-010 MemWrite  input  1  data-memory write enable.
REQ-011 WriteData  input  32  store data.
REQ-012 ALUOut  output  32  ALU result.
REQ-013 Zero  output  1  high when ALUOut == 0.
REQ-014 MemOut  output  32  data-memory read data.

Function
REQ-015 ALUCtrl generation SHALL be combinational.
- If ALUOp != 4'b1111, then ALUCtrl = ALUOp.
- If ALUOp == 4'b1111, Func maps as: 000000 SLL, 000010 SRL, 000011 SRA, 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
- Any other Func SHALL map to AND.
REQ-016 ALUCtrl encodings SHALL be: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110.
REQ-017 ALU result SHALL be combinational, computed mod 2^32.
- ADD/ADDU = A+B; SUB/SUBU = A-B; no overflow detection or trap.
- AND, OR, XOR, NOR are bitwise.
REQ-018 Shifts: SLL = A << B[4:0]; SRL = logical A >> B[4:0]; SRA = arithmetic A >> B[4:0] (sign-filled); B[31:5] is ignored.
REQ-019 LUI = {B[15:0], 16'h0000}; A is ignored.
REQ-020 SLT = 32'd1 if A < B signed, else 0. SLTU = the same comparison unsigned.
REQ-021 Unused ALUCtrl codes (0101, 1111) SHALL produce ALUOut = 0.
REQ-022 Zero SHALL be the combinational reduction-NOR of ALUOut.
REQ-023 Data-memory word address SHALL be ALUOut[ADDR_W+1:2]. ALUOut[1:0] and the upper bits are ignored, so addresses wrap modulo 256 bytes.
REQ-024 Read: MemOut SHALL be combinational, equal to mem[addr] when MemRead = 1, and 32'h0 when MemRead = 0.
REQ-025 Write: on a rising CLK edge with MemWrite = 1 and Reset = 0, mem[addr] <= WriteData. The new value is visible on MemOut after the edge, not before.
REQ-026 Simultaneous MemRead and MemWrite to the same address SHALL return the old data until the edge, then the new data.
REQ-027 The ALU and control path SHALL have no state and zero-cycle latency.

Reset
REQ-028 On a rising CLK edge with Reset = 1, all 64 memory words SHALL clear to 0, and any simultaneous MemWrite SHALL be ignored.
REQ-029 After reset, MemOut SHALL read 0 at every address. ALUOut and Zero depend only on the current inputs.

Verification
REQ-030 ALUOp=1111, Func=100000, A=32'h7FFFFFFF, B=1 -> ALUOut=32'h80000000, Zero=0. Func=100010 with A=B=5 -> ALUOut=0, Zero=1.
REQ-031 A=32'h80000000, B=4 -> SRA gives 32'hF8000000, SRL gives 32'h08000000, SLL gives 0 with Zero=1. ALUOp=1110, B=32'h1234 -> ALUOut=32'h12340000.
REQ-032 A=32'hFFFFFFFF, B=1 -> SLT gives 1, SLTU gives 0. NOR with A=B=0 gives 32'hFFFFFFFF. Func=111111 behaves as AND.
REQ-033 Store then load:
- Cycle 1: ALUOp=0010, A=32'h10, B=4, MemWrite=1, WriteData=32'hDEADBEEF; this writes word 5.
- Next cycle: MemRead=1, same address -> MemOut=32'hDEADBEEF.
- MemRead=0 -> MemOut=0.
REQ-034 Address wrap: write 32'hA5A5A5A5 at ALUOut=32'h104, then read at ALUOut=32'h4 -> MemOut=32'hA5A5A5A5.
REQ-035 Reset: write nonzero data to words 0 and 63, then assert Reset for one edge together with MemWrite=1 -> both words read 0, and the write is dropped.

Source files
------------

// File: rtl/alu_mem_datapath.sv
// Single-cycle ALU with R-type function decode feeding a 64-word data memory.
// ALU and control are purely combinational; only the memory array holds state.
module alu_mem_datapath #(
  parameter int ADDR_W = 6
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic [3:0]  ALUOp,
  input  logic [5:0]  Func,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ALUOut,
  output logic        Zero,
  output logic [31:0] MemOut
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SLL  = 4'b0011;
  localparam logic [3:0] CTRL_SRL  = 4'b0100;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_ADDU = 4'b1000;
  localparam logic [3:0] CTRL_SUBU = 4'b1001;
  localparam logic [3:0] CTRL_XOR  = 4'b1010;
  localparam logic [3:0] CTRL_SLTU = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_SRA  = 4'b1101;
  localparam logic [3:0] CTRL_LUI  = 4'b1110;

  logic [3:0]        w_alu_ctrl;
  logic [31:0]       w_alu_out;
  logic [4:0]        w_shamt;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       r_mem [DEPTH];

  assign w_shamt = BusB[4:0];

  // ALU control: pass ALUOp through, or decode Func when ALUOp is all ones
  always_comb begin
    w_alu_ctrl = CTRL_AND;
    if (ALUOp != 4'b1111) begin
      w_alu_ctrl = ALUOp;
    end else begin
      case (Func)
        6'b000000: w_alu_ctrl = CTRL_SLL;
        6'b000010: w_alu_ctrl = CTRL_SRL;
        6'b000011: w_alu_ctrl = CTRL_SRA;
        6'b100000: w_alu_ctrl = CTRL_ADD;
        6'b100001: w_alu_ctrl = CTRL_ADDU;
        6'b100010: w_alu_ctrl = CTRL_SUB;
        6'b100011: w_alu_ctrl = CTRL_SUBU;
        6'b100100: w_alu_ctrl = CTRL_AND;
        6'b100101: w_alu_ctrl = CTRL_OR;
        6'b100110: w_alu_ctrl = CTRL_XOR;
        6'b100111: w_alu_ctrl = CTRL_NOR;
        6'b101010: w_alu_ctrl = CTRL_SLT;
        6'b101011: w_alu_ctrl = CTRL_SLTU;
        default:   w_alu_ctrl = CTRL_AND;
      endcase
    end
  end

  // ALU result; signed and unsigned add/sub are identical since overflow is not trapped
  always_comb begin
    w_alu_out = 32'h0000_0000;
    case (w_alu_ctrl)
      CTRL_AND:  w_alu_out = BusA & BusB;
      CTRL_OR:   w_alu_out = BusA | BusB;
      CTRL_ADD:  w_alu_out = BusA + BusB;
      CTRL_ADDU: w_alu_out = BusA + BusB;
      CTRL_SUB:  w_alu_out = BusA - BusB;
      CTRL_SUBU: w_alu_out = BusA - BusB;
      CTRL_XOR:  w_alu_out = BusA ^ BusB;
      CTRL_NOR:  w_alu_out = ~(BusA | BusB);
      CTRL_SLL:  w_alu_out = BusA << w_shamt;
      CTRL_SRL:  w_alu_out = BusA >> w_shamt;
      CTRL_SRA:  w_alu_out = $signed(BusA) >>> w_shamt;
      CTRL_SLT:  w_alu_out = ($signed(BusA) < $signed(BusB)) ? 32'd1 : 32'd0;
      CTRL_SLTU: w_alu_out = (BusA < BusB) ? 32'd1 : 32'd0;
      CTRL_LUI:  w_alu_out = {BusB[15:0], 16'h0000};
      default:   w_alu_out = 32'h0000_0000;
    endcase
  end

  assign ALUOut = w_alu_out;
  assign Zero   = ~|w_alu_out;
  // Byte address from the ALU; low two bits and upper bits drop out, so addresses wrap
  assign w_addr = w_alu_out[ADDR_W+1:2];

  // Asynchronous read port, gated to zero when not reading
  always_comb begin
    MemOut = 32'h0000_0000;
    if (MemRead) begin
      MemOut = r_mem[w_addr];
    end else begin
      MemOut = 32'h0000_0000;
    end
  end

  // Memory array: reset clears every word and overrides any concurrent write
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (MemWrite) begin
      r_mem[w_addr] <= WriteData;
    end
  end

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Directed-vector bench for alu_mem_datapath with hand-computed expectations.
module tb_alu_mem_datapath;

  logic        CLK;
  logic        Reset;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic [3:0]  ALUOp;
  logic [5:0]  Func;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ALUOut;
  logic        Zero;
  logic [31:0] MemOut;

  int n_vec;
  int n_err;

  alu_mem_datapath #(.ADDR_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .BusA(BusA), .BusB(BusB), .ALUOp(ALUOp),
    .Func(Func), .MemRead(MemRead), .MemWrite(MemWrite), .WriteData(WriteData),
    .ALUOut(ALUOut), .Zero(Zero), .MemOut(MemOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [5:0] fn,
                     input logic [31:0] a, input logic [31:0] b);
    ALUOp = op;
    Func  = fn;
    BusA  = a;
    BusB  = b;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1; BusA = 32'h0; BusB = 32'h0; ALUOp = 4'b0000; Func = 6'b000000;
    MemRead = 1'b0; MemWrite = 1'b0; WriteData = 32'h0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state: memory reads zero, MemRead low gates output
    MemRead = 1'b1;
    for (int i = 0; i < 64; i += 21) begin
      alu(4'b0010, 6'b000000, 32'h0, 32'(i * 4));
      chk($sformatf("rst_word%0d", i), MemOut, 32'h0);
    end
    alu(4'b0010, 6'b000000, 32'h0, 32'hFC);
    chk("rst_word63", MemOut, 32'h0);
    MemRead = 1'b0;

    // Arithmetic and logic
    alu(4'b1111, 6'b100000, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf", ALUOut, 32'h8000_0000);
    chk("add_ovf_zero", {31'h0, Zero}, 32'h0);
    alu(4'b1111, 6'b100010, 32'h5, 32'h5);
    chk("sub_eq", ALUOut, 32'h0);
    chk("sub_eq_zero", {31'h0, Zero}, 32'h1);
    alu(4'b1111, 6'b100011, 32'h3, 32'h5);
    chk("subu_neg", ALUOut, 32'hFFFF_FFFE);
    alu(4'b1111, 6'b100001, 32'hFFFF_FFFF, 32'h2);
    chk("addu_wrap", ALUOut, 32'h0000_0001);
    alu(4'b1111, 6'b100110, 32'hF0F0_1234, 32'hFF00_00FF);
    chk("xor", ALUOut, 32'h0FF0_12CB);
    alu(4'b0001, 6'b000000, 32'h0000_00F0, 32'h0000_0F00);
    chk("or_op", ALUOut, 32'h0000_0FF0);
    alu(4'b1111, 6'b100111, 32'h0, 32'h0);
    chk("nor_zero", ALUOut, 32'hFFFF_FFFF);
    alu(4'b1111, 6'b111111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("func_dflt_and", ALUOut, 32'hF000_F000);
    alu(4'b0101, 6'b000000, 32'h1, 32'h1);
    chk("unused_0101", ALUOut, 32'h0);
    chk("unused_zero", {31'h0, Zero}, 32'h1);

    // Shifts and LUI
    alu(4'b1111, 6'b000011, 32'h8000_0000, 32'h4);
    chk("sra", ALUOut, 32'hF800_0000);
    alu(4'b1111, 6'b000010, 32'h8000_0000, 32'h4);
    chk("srl", ALUOut, 32'h0800_0000);
    alu(4'b1111, 6'b000000, 32'h8000_0000, 32'h4);
    chk("sll_out", ALUOut, 32'h0);
    chk("sll_zero", {31'h0, Zero}, 32'h1);
    alu(4'b1111, 6'b000000, 32'h1, 32'h21);
    chk("sll_bhi_ignored", ALUOut, 32'h2);
    alu(4'b1110, 6'b000000, 32'hFFFF_FFFF, 32'h1234);
    chk("lui", ALUOut, 32'h1234_0000);

    // Compares
    alu(4'b1111, 6'b101010, 32'hFFFF_FFFF, 32'h1);
    chk("slt", ALUOut, 32'h1);
    alu(4'b1111, 6'b101011, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", ALUOut, 32'h0);

    // Store then load at word 5
    MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
    alu(4'b0010, 6'b000000, 32'h10, 32'h4);
    chk("st_before_edge", MemOut, 32'h0);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("ld_word5", MemOut, 32'hDEAD_BEEF);
    MemRead = 1'b0;
    #1;
    chk("ld_rd_off", MemOut, 32'h0);

    // Read-during-write same address: old then new
    MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'h1111_2222;
    #1;
    chk("rdw_old", MemOut, 32'hDEAD_BEEF);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("rdw_new", MemOut, 32'h1111_2222);

    // Address wrap: 0x104 aliases 0x4, byte offset ignored
    MemWrite = 1'b1; WriteData = 32'hA5A5_A5A5;
    alu(4'b0010, 6'b000000, 32'h100, 32'h4);
    tick();
    MemWrite = 1'b0;
    alu(4'b0010, 6'b000000, 32'h0, 32'h4);
    chk("wrap_rd", MemOut, 32'hA5A5_A5A5);
    alu(4'b0010, 6'b000000, 32'h5, 32'h2);
    chk("wrap_byteoff", MemOut, 32'hA5A5_A5A5);
    alu(4'b0010, 6'b000000, 32'h0, 32'h14);
    chk("word5_kept", MemOut, 32'h1111_2222);

    // Reset clears memory and drops a concurrent write
    MemWrite = 1'b1; WriteData = 32'h0000_0011;
    alu(4'b0010, 6'b000000, 32'h0, 32'h0);
    tick();
    WriteData = 32'h0000_0063;
    alu(4'b0010, 6'b000000, 32'h0, 32'hFC);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("pre_rst_w63", MemOut, 32'h0000_0063);
    alu(4'b0010, 6'b000000, 32'h0, 32'h0);
    chk("pre_rst_w0", MemOut, 32'h0000_0011);
    Reset = 1'b1; MemWrite = 1'b1; WriteData = 32'hFFFF_FFFF;
    tick();
    Reset = 1'b0; MemWrite = 1'b0;
    #1;
    chk("post_rst_w0", MemOut, 32'h0);
    alu(4'b0010, 6'b000000, 32'h0, 32'hFC);
    chk("post_rst_w63", MemOut, 32'h0);
    alu(4'b0010, 6'b000000, 32'h0, 32'h4);
    chk("post_rst_w1", MemOut, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
